// File: rtl/cpu_pkg.sv
// Shared core types for the fetch path: FSM state, instruction FIFO entry and reset PC.
package cpu_pkg;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Instruction FIFO of {pc, instr} entries; push and pop in one cycle keep the count,
// clear empties it and wins over a same-cycle push or pop.
module ifetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          clear_i,
  input  logic          push_i,
  input  fetch_entry_t  push_dat_i,
  input  logic          pop_i,
  output fetch_entry_t  head_dat_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop  = pop_i && (count_q != '0);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_dat_o = mem_q[rd_ptr_q];
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: issues word reads while FIFO plus in-flight stays below DEPTH,
// buffers in-order responses with their PC, and discards stale responses after a redirect.
module ifetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_t  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   occupancy;
  logic          fifo_empty, fifo_push, fifo_pop;
  logic          credit_ok, req_fire, rsp_ok;
  fetch_entry_t  rsp_entry, head_entry;

  assign occupancy     = {1'b0, fifo_count} + {1'b0, inflight_q};
  assign credit_ok     = occupancy < (CW + 1)'(DEPTH);
  assign mem_req_valid = nreset && (state_q == FETCH) && credit_ok && !redirect_valid;
  assign mem_req_addr  = fetch_pc_q;
  assign req_fire      = mem_req_valid && mem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_ok    = mem_rsp_valid && (inflight_q != '0);
  assign fifo_push = rsp_ok && (state_q == FETCH) && !redirect_valid;

  // In FETCH every outstanding request is one of the words just below fetch_pc,
  // so the oldest one (the one answering now) sits inflight words back.
  assign rsp_entry.pc    = fetch_pc_q - 32'({inflight_q, 2'b00});
  assign rsp_entry.instr = mem_rsp_data;

  assign instr_valid = nreset && !fifo_empty && !redirect_valid;
  assign fifo_pop    = instr_valid && instr_ready;
  assign instr       = head_entry.instr;
  assign instr_pc    = head_entry.pc;

  ifetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .nreset    (nreset),
    .clear_i   (redirect_valid),
    .push_i    (fifo_push),
    .push_dat_i(rsp_entry),
    .pop_i     (fifo_pop),
    .head_dat_o(head_entry),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q;
    inflight_d = inflight_q;

    case ({req_fire, rsp_ok})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase

    if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;

    if (redirect_valid) begin
      // Everything still outstanding after this edge belongs to the old path.
      fetch_pc_d = word_align(redirect_pc);
      discard_d  = inflight_d;
      state_d    = (inflight_d != '0) ? FLUSH : FETCH;
    end else if (state_q == FLUSH) begin
      if (rsp_ok) discard_d = discard_q - CW'(1);
      if (discard_d == '0) state_d = FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed and randomized bench for ifetch_unit against an in-order memory model and
// an address-stream reference: after reset or a redirect, requests and deliveries walk T, T+4, ...
module tb_ifetch_unit;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam int          DEPTH  = 2;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  logic        clk = 1'b0;
  logic        nreset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  int checks = 0;
  int errors = 0;

  pend_t       pend_q[$];
  logic [31:0] req_log[$];
  logic [31:0] deliv_log[$];
  logic [31:0] exp_req, exp_ins, prev_addr;
  logic        prev_stall;
  int          cyc, rsp_cnt, rdy_pct, lat_min, lat_max;

  ifetch_unit #(
    .RESET_PC(RST_PC),
    .DEPTH   (DEPTH)
  ) dut (
    .clk           (clk),
    .nreset        (nreset),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: observe one cycle's handshakes just before the edge that commits them.
  task automatic sample();
    if (!nreset) begin
      chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
      chk("rst_instr_valid", 32'(instr_valid), 32'd0);
      pend_q.delete();
      exp_req    = RST_PC;
      exp_ins    = RST_PC;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !redirect_valid) begin
        chk("hold_valid", 32'(mem_req_valid), 32'd1);
        chk("hold_addr", mem_req_addr, prev_addr);
      end
      if (redirect_valid) begin
        chk("redir_req_valid", 32'(mem_req_valid), 32'd0);
        chk("redir_instr_valid", 32'(instr_valid), 32'd0);
      end
      if (mem_req_valid && mem_req_ready) begin
        chk("req_addr", mem_req_addr, exp_req);
        chk("req_credit", 32'((pend_q.size() + int'(mem_rsp_valid)) < DEPTH), 32'd1);
        pend_q.push_back('{addr: mem_req_addr, due: cyc + $urandom_range(lat_max, lat_min)});
        req_log.push_back(mem_req_addr);
        exp_req = exp_req + 32'd4;
      end
      if (instr_valid && instr_ready) begin
        chk("deliv_pc", instr_pc, exp_ins);
        chk("deliv_instr", instr, instr_of(exp_ins));
        deliv_log.push_back(instr_pc);
        exp_ins = exp_ins + 32'd4;
      end
      if (redirect_valid) begin
        exp_req = redirect_pc & ~32'h3;
        exp_ins = redirect_pc & ~32'h3;
      end
      prev_stall = mem_req_valid && !mem_req_ready;
      prev_addr  = mem_req_addr;
    end
  endtask

  task automatic drive_mem();
    mem_req_ready = ($urandom_range(99) < rdy_pct);
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 32'h0;
    if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = instr_of(pend_q[0].addr);
      void'(pend_q.pop_front());
      rsp_cnt++;
    end
  endtask

  // Returns 1 time unit after a rising edge, with the memory side already driven.
  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    cyc++;
    drive_mem();
  endtask

  task automatic wait_deliv(input int n, input string tag);
    int k = 0;
    while (deliv_log.size() < n && k < 100) begin
      tick();
      k++;
    end
    chk(tag, 32'(deliv_log.size() >= n), 32'd1);
  endtask

  task automatic wait_req(input int n, input string tag);
    int k = 0;
    while (req_log.size() < n && k < 100) begin
      tick();
      k++;
    end
    chk(tag, 32'(req_log.size() >= n), 32'd1);
  endtask

  // Wait for two requests outstanding, none answering now and nothing buffered.
  task automatic wait_two_inflight(input string tag);
    int  k  = 0;
    logic ok = 1'b0;
    while (!ok && k < 100) begin
      tick();
      #1;
      ok = (pend_q.size() == 2) && !mem_rsp_valid && !instr_valid;
      k++;
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    int base_req, base_del, base_rsp;
    logic ok;
    nreset = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;
    cyc = 0; rsp_cnt = 0; rdy_pct = 100; lat_min = 1; lat_max = 1;
    exp_req = RST_PC; exp_ins = RST_PC; prev_addr = RST_PC; prev_stall = 1'b0;

    repeat (3) tick();
    nreset = 1'b1;

    // Reset release, consumer stalled: two requests then credit stall, two held entries.
    repeat (12) tick();
    #1;
    chk("a_req_count", 32'(req_log.size()), 32'd2);
    chk("a_req0", req_log[0], 32'h8000_0000);
    chk("a_req1", req_log[1], 32'h8000_0004);
    chk("a_instr_valid", 32'(instr_valid), 32'd1);
    chk("a_head_pc", instr_pc, 32'h8000_0000);
    chk("a_head_instr", instr, instr_of(32'h8000_0000));
    instr_ready = 1'b1;
    wait_deliv(2, "a_drain_timeout");
    chk("a_deliv0", deliv_log[0], 32'h8000_0000);
    chk("a_deliv1", deliv_log[1], 32'h8000_0004);

    // Misaligned redirect with two in flight: no new request until both are dropped.
    lat_min = 6; lat_max = 6;
    wait_two_inflight("b_setup_timeout");
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0102;
    base_req = req_log.size(); base_del = deliv_log.size(); base_rsp = rsp_cnt;
    tick();
    redirect_valid = 1'b0;
    wait_req(base_req + 1, "b_req_timeout");
    chk("b_first_req", req_log[base_req], 32'h8000_0100);
    chk("b_dropped_rsps", 32'(rsp_cnt - base_rsp), 32'd2);
    wait_deliv(base_del + 1, "b_deliv_timeout");
    chk("b_first_deliv", deliv_log[base_del], 32'h8000_0100);

    // Redirect landing in the same cycle as a response.
    lat_min = 1; lat_max = 1;
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      tick();
      #1;
      ok = mem_rsp_valid;
    end
    chk("c_setup_timeout", 32'(ok), 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
    base_del = deliv_log.size();
    tick();
    redirect_valid = 1'b0;
    wait_deliv(base_del + 1, "c_deliv_timeout");
    chk("c_first_deliv", deliv_log[base_del], 32'h8000_0200);

    // Address wrap at the top of the space.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    base_req = req_log.size(); base_del = deliv_log.size();
    tick();
    redirect_valid = 1'b0;
    wait_req(base_req + 2, "d_req_timeout");
    chk("d_req_top", req_log[base_req], 32'hFFFF_FFFC);
    chk("d_req_wrap", req_log[base_req + 1], 32'h0000_0000);
    wait_deliv(base_del + 2, "d_deliv_timeout");
    chk("d_deliv_wrap", deliv_log[base_del + 1], 32'h0000_0000);

    // Reset while flushing: restart at RESET_PC with nothing outstanding or buffered.
    lat_min = 8; lat_max = 8;
    wait_two_inflight("e_setup_timeout");
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0300;
    tick();
    redirect_valid = 1'b0;
    tick();
    nreset = 1'b0;
    repeat (2) tick();
    nreset = 1'b1;
    #1;
    chk("e_fifo_empty", 32'(instr_valid), 32'd0);
    chk("e_req_valid", 32'(mem_req_valid), 32'd1);
    chk("e_req_addr", mem_req_addr, RST_PC);
    base_req = req_log.size(); base_del = deliv_log.size();
    wait_req(base_req + 1, "e_req_timeout");
    chk("e_first_req", req_log[base_req], RST_PC);
    wait_deliv(base_del + 1, "e_deliv_timeout");
    chk("e_first_deliv", deliv_log[base_del], RST_PC);

    // Random traffic: stalls, variable latency, back-to-back and in-flush redirects.
    rdy_pct = 70; lat_min = 1; lat_max = 4;
    base_del = deliv_log.size();
    for (int i = 0; i < 1500; i++) begin
      tick();
      instr_ready    = ($urandom_range(3) != 0);
      redirect_valid = ($urandom_range(24) == 0);
      redirect_pc    = $urandom;
    end
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    repeat (30) tick();
    chk("f_progress", 32'(deliv_log.size() > base_del + 100), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
